mem_boot_loader: RTL and testbench

Boot-time loader that sits directly upstream of the CPU's `memoryFile`. It receives a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and writes them into `memoryFile` from address 0 through its `address` / `mem_write_data` / `mem_write_en` port. It holds the CPU in reset until the image has been loaded and its checksum verified.

---
 rtl/boot_pkg.sv | 24 ++
 rtl/boot_byte_packer.sv | 34 +++
 rtl/mem_boot_loader.sv | 127 ++++++++++++
 tb/tb_mem_boot_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot-time memory loader.
package boot_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } boot_state_t;

    // States in which the loader is willing to take a stream byte.
    function automatic logic state_accepts_byte(input boot_state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/boot_byte_packer.sv
// Holds the pending high byte, forms big-endian words and keeps the running XOR
// over every accepted length/data byte.
module boot_byte_packer
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              accept_hi,
    input  logic              accept_lo,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] xor_sum
);

    logic [BYTE_W-1:0] hi_byte;

    always_ff @(posedge clk) begin
        if (clear) begin
            hi_byte <= '0;
            xor_sum <= '0;
        end else begin
            if (accept_hi) begin
                hi_byte <= byte_in;
            end
            if (accept_hi || accept_lo) begin
                xor_sum <= xor_sum ^ byte_in;
            end
        end
    end

    // The low byte is taken straight from the stream so the word is ready on accept.
    assign word = {hi_byte, byte_in};

endmodule

// File: rtl/mem_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into memoryFile and
// holds the CPU in reset until the image is loaded and verified.
module mem_boot_loader
    import boot_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] address,
    output logic [WORD_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [WORD_W-1:0] words_loaded
);

    boot_state_t       state;
    logic [WORD_W-1:0] index;
    logic [WORD_W-1:0] word_count;
    logic [WORD_W-1:0] index_inc;
    logic [WORD_W-1:0] packed_word;
    logic [BYTE_W-1:0] xor_sum;
    logic              accept;
    logic              pack_hi;
    logic              pack_lo;
    logic              oversize;

    assign in_ready  = !rst && state_accepts_byte(state);
    assign accept    = in_valid && in_ready;
    assign index_inc = index + 16'd1;

    // Length bytes share the packer path so the length word forms like a data word.
    assign pack_hi  = accept && ((state == S_LEN_HI) || (state == S_DATA_HI));
    assign pack_lo  = accept && ((state == S_LEN_LO) || (state == S_DATA_LO));
    assign oversize = {16'd0, packed_word} > 32'(MEM_DEPTH);

    boot_byte_packer u_packer (
        .clk      (clk),
        .clear    (rst),
        .accept_hi(pack_hi),
        .accept_lo(pack_lo),
        .byte_in  (in_data),
        .word     (packed_word),
        .xor_sum  (xor_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_LEN_HI;
            index          <= '0;
            word_count     <= '0;
            address        <= '0;
            mem_write_data <= '0;
            mem_write_en   <= 1'b0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            words_loaded   <= '0;
        end else begin
            mem_write_en <= 1'b0;
            case (state)
                S_LEN_HI: begin
                    if (accept) begin
                        state <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        word_count <= packed_word;
                        if (oversize) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else if (packed_word == '0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        state <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        state          <= S_WRITE;
                        mem_write_en   <= 1'b1;
                        mem_write_data <= packed_word;
                        address        <= index;
                    end
                end
                // The strobe cycle: no byte is taken, the source holds its next byte.
                S_WRITE: begin
                    index        <= index_inc;
                    address      <= index_inc;
                    words_loaded <= words_loaded + 16'd1;
                    state        <= (index_inc == word_count) ? S_CSUM : S_DATA_HI;
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == xor_sum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_DONE: state <= S_DONE;
                S_ERR:  state <= S_ERR;
                default: begin
                    state <= S_ERR;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Randomized bench for mem_boot_loader: a byte-count based stream model predicts
// every output each cycle, and the write port feeds a bench-side memoryFile.
module tb_mem_boot_loader;

    localparam int DEPTH = 256;

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] address;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    mem_boot_loader #(.MEM_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .address       (address),
        .mem_write_data(mem_write_data),
        .mem_write_en  (mem_write_en),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .err           (err),
        .words_loaded  (words_loaded)
    );

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench-side memoryFile plus write-strobe bookkeeping.
    logic [15:0] tb_mem [DEPTH];
    logic        mem_clear = 1'b0;
    logic        gap_track_en = 1'b0;
    int          cycle = 0;
    int          wen_pulses = 0;
    int          last_wen_cycle = -1;
    int          gap_bad = 0;

    always @(posedge clk) begin
        cycle++;
        if (mem_clear) begin
            foreach (tb_mem[i]) tb_mem[i] <= 16'h0000;
        end else if (mem_write_en) begin
            tb_mem[address[7:0]] <= mem_write_data;
        end
        if (!gap_track_en) begin
            last_wen_cycle = -1;
        end
        if (mem_write_en) begin
            wen_pulses++;
            if (gap_track_en && last_wen_cycle >= 0 && cycle - last_wen_cycle != 3) gap_bad++;
            if (gap_track_en) last_wen_cycle = cycle;
        end
    end

    // Reference model: progress is the number of bytes consumed; every completed
    // data word costs one extra stall cycle in which nothing is consumed.
    int          m_cnt = 0;
    int          m_words = 0;
    int          m_j;
    logic        m_stall = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic        m_acc;
    logic [7:0]  m_xor = 8'h00;
    logic [7:0]  m_hi = 8'h00;
    logic [15:0] m_n = 16'h0000;
    logic        e_wen = 1'b0;
    logic [15:0] e_addr = 16'h0000;
    logic [15:0] e_wdata = 16'h0000;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_words = 0; m_stall = 0; m_done = 0; m_err = 0;
            m_xor = 0; m_hi = 0; m_n = 0;
            e_wen = 0; e_addr = 0; e_wdata = 0;
        end else begin
            m_acc = in_valid && !m_stall && !m_done && !m_err;
            e_wen = 1'b0;
            if (m_stall) begin
                m_stall = 1'b0;
                m_words++;
                e_addr = 16'(m_words);
            end else if (m_acc) begin
                if (m_cnt == 0) begin
                    m_hi  = in_data;
                    m_xor = m_xor ^ in_data;
                end else if (m_cnt == 1) begin
                    m_n   = {m_hi, in_data};
                    m_xor = m_xor ^ in_data;
                    if (int'(m_n) > DEPTH) m_err = 1'b1;
                end else if (m_cnt < 2 + 2 * int'(m_n)) begin
                    m_j   = m_cnt - 2;
                    m_xor = m_xor ^ in_data;
                    if (m_j % 2 == 0) begin
                        m_hi = in_data;
                    end else begin
                        e_wen   = 1'b1;
                        e_wdata = {m_hi, in_data};
                        e_addr  = 16'(m_j / 2);
                        m_stall = 1'b1;
                    end
                end else begin
                    if (in_data == m_xor) m_done = 1'b1;
                    else                  m_err  = 1'b1;
                end
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("in_ready", {15'd0, in_ready}, {15'd0, !rst && !m_stall && !m_done && !m_err});
        checkOutput("mem_write_en", {15'd0, mem_write_en}, {15'd0, e_wen});
        checkOutput("address", address, e_addr);
        checkOutput("mem_write_data", mem_write_data, e_wdata);
        checkOutput("done", {15'd0, done}, {15'd0, m_done});
        checkOutput("err", {15'd0, err}, {15'd0, m_err});
        checkOutput("cpu_hold", {15'd0, cpu_hold}, {15'd0, !m_done});
        checkOutput("words_loaded", words_loaded, 16'(m_words));
    end

    function automatic bq_t buildStream(input logic [15:0] n, input wq_t w, input bit corrupt);
        bq_t        s;
        logic [7:0] x = 8'h00;
        s.push_back(n[15:8]);
        s.push_back(n[7:0]);
        foreach (w[i]) begin
            s.push_back(w[i][15:8]);
            s.push_back(w[i][7:0]);
        end
        foreach (s[i]) x = x ^ s[i];
        s.push_back(corrupt ? ~x : x);
        return s;
    endfunction

    task automatic waitAccept();
        int   tries = 0;
        logic rdy;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            tries++;
            if (tries > 40) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL accept_timeout: byte %h not accepted, required within 40 cycles", in_data);
                break;
            end
        end
    endtask

    task automatic applyStimulus(input bq_t bytes, input bit cont);
        foreach (bytes[i]) begin
            if (!cont) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = bytes[i];
            waitAccept();
        end
        in_valid = 1'b0;
    endtask

    task automatic idleOffer(input int k);
        in_valid = 1'b1;
        repeat (k) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic doReset(input int c);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (c) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic clearMem();
        mem_clear = 1'b1;
        @(posedge clk);
        #1;
        mem_clear = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bq_t s1;
        bq_t s;
        wq_t w;
        int  base;
        int  gbase;

        s1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};

        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clearMem();
        checkOutput("reset_cpu_hold", {15'd0, cpu_hold}, 16'd1);
        checkOutput("reset_in_ready", {15'd0, in_ready}, 16'd0);
        checkOutput("reset_done", {15'd0, done}, 16'd0);
        checkOutput("reset_wen", {15'd0, mem_write_en}, 16'd0);
        checkOutput("reset_words", words_loaded, 16'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", {15'd0, in_ready}, 16'd1);

        $display("[TB] two-word image with random gaps");
        base = wen_pulses;
        applyStimulus(s1, 1'b0);
        idleOffer(3);
        checkOutput("img1_mem0", tb_mem[0], 16'h1234);
        checkOutput("img1_mem1", tb_mem[1], 16'hABCD);
        checkOutput("img1_done", {15'd0, done}, 16'd1);
        checkOutput("img1_hold", {15'd0, cpu_hold}, 16'd0);
        checkOutput("img1_words", words_loaded, 16'd2);
        checkOutput("img1_pulses", 16'(wen_pulses - base), 16'd2);

        $display("[TB] empty image");
        doReset(2);
        base = wen_pulses;
        applyStimulus('{8'h00, 8'h00, 8'h00}, 1'b0);
        idleOffer(3);
        checkOutput("empty_pulses", 16'(wen_pulses - base), 16'd0);
        checkOutput("empty_done", {15'd0, done}, 16'd1);
        checkOutput("empty_words", words_loaded, 16'd0);

        $display("[TB] bad checksum");
        doReset(1);
        clearMem();
        applyStimulus('{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFF}, 1'b0);
        idleOffer(3);
        checkOutput("badcs_mem0", tb_mem[0], 16'h55AA);
        checkOutput("badcs_err", {15'd0, err}, 16'd1);
        checkOutput("badcs_done", {15'd0, done}, 16'd0);
        checkOutput("badcs_hold", {15'd0, cpu_hold}, 16'd1);
        checkOutput("badcs_ready", {15'd0, in_ready}, 16'd0);

        $display("[TB] oversize length");
        doReset(1);
        base = wen_pulses;
        applyStimulus('{8'h01, 8'h01}, 1'b1);
        checkOutput("over_err_next_cycle", {15'd0, err}, 16'd1);
        idleOffer(4);
        checkOutput("over_pulses", 16'(wen_pulses - base), 16'd0);

        $display("[TB] continuous valid, write stall spacing");
        doReset(1);
        clearMem();
        base  = wen_pulses;
        gbase = gap_bad;
        gap_track_en = 1'b1;
        applyStimulus(s1, 1'b1);
        gap_track_en = 1'b0;
        idleOffer(2);
        checkOutput("cont_gaps", 16'(gap_bad - gbase), 16'd0);
        checkOutput("cont_pulses", 16'(wen_pulses - base), 16'd2);
        checkOutput("cont_mem0", tb_mem[0], 16'h1234);
        checkOutput("cont_mem1", tb_mem[1], 16'hABCD);

        $display("[TB] reset in the middle of a load");
        doReset(1);
        clearMem();
        applyStimulus('{8'h00, 8'h02, 8'h12}, 1'b1);
        doReset(1);
        applyStimulus(s1, 1'b1);
        idleOffer(2);
        checkOutput("midrst_mem0", tb_mem[0], 16'h1234);
        checkOutput("midrst_mem1", tb_mem[1], 16'hABCD);
        checkOutput("midrst_done", {15'd0, done}, 16'd1);

        $display("[TB] full-depth image");
        doReset(1);
        clearMem();
        w.delete();
        repeat (DEPTH) w.push_back(16'($urandom));
        s = buildStream(16'(DEPTH), w, 1'b0);
        gbase = gap_bad;
        gap_track_en = 1'b1;
        applyStimulus(s, 1'b1);
        gap_track_en = 1'b0;
        idleOffer(2);
        checkOutput("full_words", words_loaded, 16'(DEPTH));
        checkOutput("full_mem_first", tb_mem[0], w[0]);
        checkOutput("full_mem_last", tb_mem[DEPTH-1], w[DEPTH-1]);
        checkOutput("full_done", {15'd0, done}, 16'd1);
        checkOutput("full_gaps", 16'(gap_bad - gbase), 16'd0);

        $display("[TB] random images");
        for (int t = 0; t < 24; t++) begin
            int n;
            bit corrupt;
            bit over;
            over    = ($urandom_range(0, 9) == 0);
            corrupt = ($urandom_range(0, 3) == 0);
            n       = $urandom_range(0, 8);
            doReset($urandom_range(1, 3));
            clearMem();
            base = wen_pulses;
            if (over) begin
                s = '{8'($urandom_range(2, 255)), 8'($urandom)};
                applyStimulus(s, 1'($urandom_range(0, 1)));
                idleOffer(3);
                checkOutput("rand_over_err", {15'd0, err}, 16'd1);
                checkOutput("rand_over_pulses", 16'(wen_pulses - base), 16'd0);
            end else begin
                w.delete();
                repeat (n) w.push_back(16'($urandom));
                s = buildStream(16'(n), w, corrupt);
                applyStimulus(s, 1'($urandom_range(0, 1)));
                idleOffer(3);
                checkOutput("rand_done", {15'd0, done}, {15'd0, !corrupt});
                checkOutput("rand_err", {15'd0, err}, {15'd0, corrupt});
                checkOutput("rand_pulses", 16'(wen_pulses - base), 16'(n));
                for (int j = 0; j < n; j++) begin
                    checkOutput("rand_mem", tb_mem[j], w[j]);
                end
            end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
